if_stage: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. Handles stall, flush and branch/jump redirect from later stages. Flags misaligned or out-of-range fetch addresses instead of passing garbage downstream.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/if_stage_if.sv | 45 ++++
 rtl/if_stage_pc_reg.sv | 37 +++
 rtl/if_stage.sv | 76 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I front end: NOP encoding, IF/ID record
// layout, bubble value and default reset PC.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned XLEN             = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } if_id_t;

  // Empty IF/ID slot: decodes as a harmless NOP and is marked not valid.
  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    32'h0,
    pc4:   32'h0,
    instr: NOP_INSTR,
    valid: 1'b0,
    fault: 1'b0
  };

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline-control, instruction-memory and
// IF/ID signals. master = the fetch stage, slave = its environment.
interface if_stage_if;

  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        if_id_fault;

  modport master (
    input  stall,
    input  flush,
    input  redirect,
    input  redirect_pc,
    input  imem_instr,
    output imem_addr,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
    output if_id_valid,
    output if_id_fault
  );

  modport slave (
    output stall,
    output flush,
    output redirect,
    output redirect_pc,
    output imem_instr,
    input  imem_addr,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
    input  if_id_valid,
    input  if_id_fault
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: next-PC selection plus the PC register itself.
// Priority is reset, then redirect (beats stall), then stall, then +4.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Next-PC mux; a redirect target is taken as-is, checking happens at fetch.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (!stall) begin
      pc_next = pc_plus4(pc);
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC drives the instruction memory address, the
// returned word is captured into IF/ID. Illegal fetch addresses capture a
// NOP tagged with fault instead of whatever the memory returned.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_p0;
  logic        ok_p0;
  if_id_t      fetch_p0;
  if_id_t      if_id_p1;

  // Word-aligned and inside memory, compared as unsigned 32-bit.
  function automatic logic fetch_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
  endfunction

  // Replace the memory word by a NOP when the address was not fetchable.
  function automatic logic [31:0] fetch_word(input logic ok,
                                             input logic [31:0] word);
    return ok ? word : NOP_INSTR;
  endfunction

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (bus.stall),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc_p0)
  );

  // ---- stage p0: PC presented to memory, fetched record assembled ----
  assign bus.imem_addr = pc_p0;
  assign ok_p0         = fetch_ok(pc_p0);

  // Candidate IF/ID contents for a normal (unstalled, unsquashed) edge.
  always_comb begin
    fetch_p0       = IF_ID_BUBBLE;
    fetch_p0.pc    = pc_p0;
    fetch_p0.pc4   = pc_plus4(pc_p0);
    fetch_p0.instr = fetch_word(ok_p0, bus.imem_instr);
    fetch_p0.valid = 1'b1;
    fetch_p0.fault = !ok_p0;
  end

  // ---- stage p1: IF/ID register ----
  // Reset, redirect and flush all squash; stall holds; otherwise capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_p1 <= IF_ID_BUBBLE;
    end else if (bus.redirect || bus.flush) begin
      if_id_p1 <= IF_ID_BUBBLE;
    end else if (!bus.stall) begin
      if_id_p1 <= fetch_p0;
    end
  end

  assign bus.if_id_pc    = if_id_p1.pc;
  assign bus.if_id_pc4   = if_id_p1.pc4;
  assign bus.if_id_instr = if_id_p1.instr;
  assign bus.if_id_valid = if_id_p1.valid;
  assign bus.if_id_fault = if_id_p1.fault;

endmodule
